// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: hold-level encodings, FSM states and boot vector.
package pipe_ctrl_pkg;

    localparam logic [1:0] HOLD_NONE = 2'b00;
    localparam logic [1:0] HOLD_PC   = 2'b01;
    localparam logic [1:0] HOLD_IF   = 2'b10;
    localparam logic [1:0] HOLD_ID   = 2'b11;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_pend.sv
// One-entry pending-redirect slot: an interrupt target always overwrites, a jump target
// only fills an empty slot, and a clear (redirect issued) beats any set.
module pipe_ctrl_pend #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_int_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    input  logic              set_jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] issue_addr_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (set_int_i) begin
            valid_d = 1'b1;
            addr_d  = int_addr_i;
        end else if (set_jump_i && !valid_q) begin
            valid_d = 1'b1;
            addr_d  = jump_addr_i;
        end
    end

    // An interrupt arriving in the issue cycle still wins over the stored target.
    assign issue_addr_o = set_int_i ? int_addr_i : addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: prioritises redirect/stall requests into PC and flush controls.
// Optional macro PIPE_CTRL_PERF_CNT_EN adds stall and redirect performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_ex_i,
    input  logic [ADDR_W-1:0] jump_addr_ex_i,
    input  logic              hold_ex_i,
    input  logic              hold_bus_i,
    input  logic              int_assert_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    output logic              int_ack_o,
    output logic [1:0]        hold_flag_o,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
`ifdef PIPE_CTRL_PERF_CNT_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       redirect_cnt_o,
`endif
    output logic              flush_o
);

    state_e            state_q, state_d;
    logic [1:0]        hold_flag_q, hold_flag_d;
    logic              jump_flag_q, jump_flag_d;
    logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
    logic              flush_q, flush_d;
    logic              int_ack_q, int_ack_d;

    logic              pend_set_int, pend_set_jump, pend_clr;
    logic [ADDR_W-1:0] pend_issue_addr;

    pipe_ctrl_pend #(
        .ADDR_W (ADDR_W)
    ) u_pend (
        .clk          (clk),
        .rst          (rst),
        .set_int_i    (pend_set_int),
        .int_addr_i   (int_addr_i),
        .set_jump_i   (pend_set_jump),
        .jump_addr_i  (jump_addr_ex_i),
        .clr_i        (pend_clr),
        .issue_addr_o (pend_issue_addr)
    );

    always_comb begin
        state_d       = state_q;
        hold_flag_d   = HOLD_NONE;
        jump_flag_d   = 1'b0;
        jump_addr_d   = '0;
        flush_d       = 1'b0;
        int_ack_d     = 1'b0;
        pend_set_int  = 1'b0;
        pend_set_jump = 1'b0;
        pend_clr      = 1'b0;
        case (state_q)
            ST_BOOT: begin
                jump_flag_d = 1'b1;
                jump_addr_d = RESET_ADDR;
                flush_d     = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                // A redirect that meets a bus stall is parked rather than dropped.
                if ((int_assert_i || jump_flag_ex_i) && hold_bus_i) begin
                    pend_set_int  = int_assert_i;
                    pend_set_jump = jump_flag_ex_i;
                    int_ack_d     = int_assert_i;
                    hold_flag_d   = HOLD_ID;
                    state_d       = ST_PEND;
                end else if (int_assert_i) begin
                    jump_flag_d = 1'b1;
                    jump_addr_d = int_addr_i;
                    flush_d     = 1'b1;
                    int_ack_d   = 1'b1;
                end else if (jump_flag_ex_i) begin
                    jump_flag_d = 1'b1;
                    jump_addr_d = jump_addr_ex_i;
                    flush_d     = 1'b1;
                end else if (hold_bus_i) begin
                    hold_flag_d = HOLD_ID;
                end else if (hold_ex_i) begin
                    hold_flag_d = HOLD_IF;
                end
            end
            ST_PEND: begin
                pend_set_int = int_assert_i;
                int_ack_d    = int_assert_i;
                if (hold_bus_i) begin
                    hold_flag_d = HOLD_ID;
                end else begin
                    jump_flag_d = 1'b1;
                    jump_addr_d = pend_issue_addr;
                    flush_d     = 1'b1;
                    pend_clr    = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            hold_flag_q <= HOLD_ID;
            jump_flag_q <= 1'b0;
            jump_addr_q <= '0;
            flush_q     <= 1'b1;
            int_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_flag_q <= hold_flag_d;
            jump_flag_q <= jump_flag_d;
            jump_addr_q <= jump_addr_d;
            flush_q     <= flush_d;
            int_ack_q   <= int_ack_d;
        end
    end

    assign hold_flag_o = hold_flag_q;
    assign jump_flag_o = jump_flag_q;
    assign jump_addr_o = jump_addr_q;
    assign flush_o     = flush_q;
    assign int_ack_o   = int_ack_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    // Counters advance together with the output register they observe.
    always_comb begin
        stall_cnt_d    = stall_cnt_q + {31'd0, (hold_flag_d != HOLD_NONE)};
        redirect_cnt_d = redirect_cnt_q + {31'd0, jump_flag_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign stall_cnt_o    = stall_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, a reset-in-PEND sequence and
// randomized traffic compared against a queue-based behavioural model.
module tb_pipe_ctrl;

    typedef struct {
        logic        rst;
        logic        jf;
        logic [31:0] ja;
        logic        hex;
        logic        hbus;
        logic        ia;
        logic [31:0] iaddr;
        logic [1:0]  e_hold;
        logic        e_jf;
        logic [31:0] e_ja;
        logic        e_fl;
        logic        e_ack;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        jump_flag_ex_i;
    logic [31:0] jump_addr_ex_i;
    logic        hold_ex_i;
    logic        hold_bus_i;
    logic        int_assert_i;
    logic [31:0] int_addr_i;
    logic        int_ack_o;
    logic [1:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        flush_o;

    int vec_count  = 0;
    int miss_count = 0;

    // Reference model state: boot redirect owed, and a queue holding at most one parked target.
    logic        m_boot;
    logic [31:0] m_slot[$];
    logic [1:0]  m_hold;
    logic        m_jf;
    logic [31:0] m_ja;
    logic        m_fl;
    logic        m_ack;

    vec_t vecs[$];

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .jump_flag_ex_i (jump_flag_ex_i),
        .jump_addr_ex_i (jump_addr_ex_i),
        .hold_ex_i      (hold_ex_i),
        .hold_bus_i     (hold_bus_i),
        .int_assert_i   (int_assert_i),
        .int_addr_i     (int_addr_i),
        .int_ack_o      (int_ack_o),
        .hold_flag_o    (hold_flag_o),
        .jump_flag_o    (jump_flag_o),
        .jump_addr_o    (jump_addr_o),
        .flush_o        (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic jf, input logic [31:0] ja,
                                input logic hex, input logic hbus, input logic ia,
                                input logic [31:0] iaddr, input logic [1:0] e_hold,
                                input logic e_jf, input logic [31:0] e_ja,
                                input logic e_fl, input logic e_ack);
        vec_t v;
        v.rst = r; v.jf = jf; v.ja = ja; v.hex = hex; v.hbus = hbus; v.ia = ia;
        v.iaddr = iaddr; v.e_hold = e_hold; v.e_jf = e_jf; v.e_ja = e_ja;
        v.e_fl = e_fl; v.e_ack = e_ack;
        return v;
    endfunction

    // Drive inputs away from the edge, then sample 1ns after the capturing edge.
    task automatic applyStimulus(input logic r, input logic jf, input logic [31:0] ja,
                                 input logic hex, input logic hbus, input logic ia,
                                 input logic [31:0] iaddr);
        @(negedge clk);
        rst            = r;
        jump_flag_ex_i = jf;
        jump_addr_ex_i = ja;
        hold_ex_i      = hex;
        hold_bus_i     = hbus;
        int_assert_i   = ia;
        int_addr_i     = iaddr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] e_hold, input logic e_jf,
                               input logic [31:0] e_ja, input logic e_fl, input logic e_ack);
        vec_count++;
        if (hold_flag_o !== e_hold || jump_flag_o !== e_jf || jump_addr_o !== e_ja ||
            flush_o !== e_fl || int_ack_o !== e_ack) begin
            miss_count++;
            $display("[TB] FAIL %s: got hold=%b jf=%b ja=%h fl=%b ack=%b, want hold=%b jf=%b ja=%h fl=%b ack=%b",
                     name, hold_flag_o, jump_flag_o, jump_addr_o, flush_o, int_ack_o,
                     e_hold, e_jf, e_ja, e_fl, e_ack);
        end
    endtask

    // Behavioural model: derives the next outputs straight from the priority rules.
    task automatic modelStep(input logic r, input logic jf, input logic [31:0] ja,
                             input logic hex, input logic hbus, input logic ia,
                             input logic [31:0] iaddr);
        logic        want;
        logic [31:0] tgt;
        m_hold = 2'b00; m_jf = 1'b0; m_ja = 32'h0; m_fl = 1'b0; m_ack = 1'b0;
        if (r) begin
            m_hold = 2'b11; m_fl = 1'b1;
            m_boot = 1'b1;
            m_slot.delete();
        end else if (m_boot) begin
            m_jf = 1'b1; m_ja = 32'h0; m_fl = 1'b1;
            m_boot = 1'b0;
        end else if (m_slot.size() != 0) begin
            if (ia) begin
                m_slot[0] = iaddr;
                m_ack = 1'b1;
            end
            if (hbus) begin
                m_hold = 2'b11;
            end else begin
                m_jf = 1'b1; m_fl = 1'b1;
                m_ja = m_slot.pop_front();
            end
        end else begin
            want = ia | jf;
            tgt  = ia ? iaddr : ja;
            m_ack = ia;
            if (want && hbus) begin
                m_slot.push_back(tgt);
                m_hold = 2'b11;
            end else if (want) begin
                m_jf = 1'b1; m_ja = tgt; m_fl = 1'b1;
            end else if (hbus) begin
                m_hold = 2'b11;
            end else if (hex) begin
                m_hold = 2'b10;
            end
        end
    endtask

    initial begin
        rst = 1'b1; jump_flag_ex_i = 1'b0; jump_addr_ex_i = 32'h0; hold_ex_i = 1'b0;
        hold_bus_i = 1'b0; int_assert_i = 1'b0; int_addr_i = 32'h0;
        m_boot = 1'b1;

        //          rst jf ja          hex hb ia iaddr        hold  jf ja          fl ack
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0, 32'h0,   2'b11, 0, 32'h0,   1, 0));
        vecs.push_back(mk(1, 1, 32'h44,  1, 1, 1, 32'h88,  2'b11, 0, 32'h0,   1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 1, 32'h0,   1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 1, 0, 0, 32'h0,   2'b00, 1, 32'h100, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 32'h0, 1, 0, 0, 32'h0, 2'b10, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 0, 1, 0, 32'h0,   2'b11, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h0,   2'b11, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h0,   2'b11, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 1, 32'h200, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 0, 1, 0, 32'h0,   2'b11, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'h80,  2'b11, 0, 32'h0,   0, 1));
        vecs.push_back(mk(0, 1, 32'h300, 1, 1, 0, 32'h0,   2'b11, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 1, 32'h80,  1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 32'h500, 1, 0, 1, 32'h40,  2'b00, 1, 32'h40,  1, 1));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 0, 32'h0,   2'b11, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'hC0,  2'b11, 0, 32'h0,   0, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 1, 32'hC0,  1, 0));
        vecs.push_back(mk(0, 1, 32'h600, 0, 0, 0, 32'h0,   2'b00, 1, 32'h600, 1, 0));
        vecs.push_back(mk(0, 1, 32'h604, 0, 0, 0, 32'h0,   2'b00, 1, 32'h604, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].jf, vecs[i].ja, vecs[i].hex,
                          vecs[i].hbus, vecs[i].ia, vecs[i].iaddr);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_hold, vecs[i].e_jf,
                        vecs[i].e_ja, vecs[i].e_fl, vecs[i].e_ack);
        end

        // Reset while a redirect is parked and the bus is still stalled.
        applyStimulus(0, 1, 32'h200, 0, 1, 0, 32'h0);
        checkOutput("rstpend_park", 2'b11, 0, 32'h0, 0, 0);
        applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h0);
        checkOutput("rstpend_rst", 2'b11, 0, 32'h0, 1, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("rstpend_boot", 2'b00, 1, 32'h0, 1, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("rstpend_idle1", 2'b00, 0, 32'h0, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("rstpend_idle2", 2'b00, 0, 32'h0, 0, 0);

        // Randomized traffic, starting from a fresh reset so the model is aligned.
        for (int c = 0; c < 2000; c++) begin
            logic        r, jf, hex, hbus, ia;
            logic [31:0] ja, iaddr;
            r     = (c == 0) ? 1'b1 : ($urandom_range(0, 63) == 0);
            jf    = ($urandom_range(0, 3) == 0);
            ja    = $urandom;
            hex   = ($urandom_range(0, 3) == 0);
            hbus  = ($urandom_range(0, 2) == 0);
            ia    = ($urandom_range(0, 7) == 0);
            iaddr = $urandom;
            modelStep(r, jf, ja, hex, hbus, ia, iaddr);
            applyStimulus(r, jf, ja, hex, hbus, ia, iaddr);
            checkOutput($sformatf("rand%0d", c), m_hold, m_jf, m_ja, m_fl, m_ack);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
